// File: rtl/gpu_rect_raster_if.sv
// Command-FIFO / framebuffer bus of the rectangle rasteriser.
// The master side is the rasteriser. The slave side is the FIFO and framebuffer environment.
interface gpu_rect_raster_if;
    logic        start;
    logic        empty;
    logic        ren;
    logic [65:0] read_data;
    logic [18:0] addr;
    logic [5:0]  dout;
    logic        wen;
    logic        done;

    modport master (
        input  start, empty, read_data,
        output ren, addr, dout, wen, done
    );

    modport slave (
        output start, empty, read_data,
        input  ren, addr, dout, wen, done
    );
endinterface

// File: rtl/gpu_rect_raster.sv
// Rectangle rasteriser.
// Fetches one command word at a time from a FIFO.
// FILL_RECT writes a clipped rectangle and CLEAR writes the full screen.
// Pixels are written one per cycle in raster order.
module gpu_rect_raster #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    gpu_rect_raster_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, DRAW} state_t;

    localparam logic [9:0]  XMAX   = 10'(H_RES - 1);
    localparam logic [9:0]  YMAX   = 10'(V_RES - 1);
    localparam logic [10:0] HRES11 = 11'(H_RES);
    localparam logic [10:0] VRES11 = 11'(V_RES);
    localparam logic [18:0] HSTEP  = 19'(H_RES);

    state_t      state_q;
    logic        ren_q, wen_q;
    logic [18:0] addr_q, row_q;
    logic [5:0]  dout_q;
    logic [9:0]  x_q, y_q, x0_q, x1_q, y1_q;

    logic [1:0]  op;
    logic [9:0]  rx0, ry0, rx1, ry1, x1c, y1c;
    logic [9:0]  x0_d, y0_d, x1_d, y1_d;
    logic [5:0]  color_d;
    logic        draw_d;
    logic [18:0] row_d;
    logic        unused_bits;

    assign op      = bus.read_data[65:64];
    assign rx0     = bus.read_data[63:54];
    assign ry0     = bus.read_data[53:44];
    assign rx1     = bus.read_data[43:34];
    assign ry1     = bus.read_data[33:24];
    assign color_d = bus.read_data[23:18];
    assign unused_bits = ^bus.read_data[17:0];

    // Decode the fetched word into clipped draw bounds and decide whether anything is drawn.
    always_comb begin
        x0_d   = '0;
        y0_d   = '0;
        x1_d   = '0;
        y1_d   = '0;
        draw_d = 1'b0;
        x1c    = (rx1 > XMAX) ? XMAX : rx1;
        y1c    = (ry1 > YMAX) ? YMAX : ry1;
        case (op)
            2'b01: begin
                x0_d   = rx0;
                y0_d   = ry0;
                x1_d   = x1c;
                y1_d   = y1c;
                draw_d = !((rx0 > x1c) || (ry0 > y1c) ||
                           ({1'b0, rx0} >= HRES11) || ({1'b0, ry0} >= VRES11));
            end
            2'b10: begin
                x1_d   = XMAX;
                y1_d   = YMAX;
                draw_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Compute the starting row base H_RES*y0 as a shift-and-add over the bits of y0.
    // This keeps a general multiplier out of the address path.
    always_comb begin
        row_d = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (y0_d[i]) row_d = row_d + (HSTEP << i);
        end
    end

    // Sequencer: IDLE -> FETCH -> DECODE -> (DRAW) -> IDLE.
    // All bus outputs are registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            dout_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wen_q <= 1'b0;
                    if (bus.start && !bus.empty) begin
                        state_q <= FETCH;
                        ren_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    ren_q   <= 1'b0;
                    state_q <= DECODE;
                end
                DECODE: begin
                    x0_q <= x0_d;
                    x1_q <= x1_d;
                    y1_q <= y1_d;
                    x_q  <= x0_d;
                    y_q  <= y0_d;
                    row_q <= row_d;
                    if (draw_d) begin
                        state_q <= DRAW;
                        wen_q   <= 1'b1;
                        addr_q  <= row_d + {9'b0, x0_d};
                        dout_q  <= color_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAW: begin
                    if (x_q == x1_q && y_q == y1_q) begin
                        state_q <= IDLE;
                        wen_q   <= 1'b0;
                    end else if (x_q == x1_q) begin
                        x_q    <= x0_q;
                        y_q    <= y_q + 10'd1;
                        row_q  <= row_q + HSTEP;
                        addr_q <= row_q + HSTEP + {9'b0, x0_q};
                    end else begin
                        x_q    <= x_q + 10'd1;
                        addr_q <= addr_q + 19'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ren  = ren_q;
    assign bus.wen  = wen_q;
    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign bus.done = !rst_ni || ((state_q == IDLE) && (bus.empty || !bus.start));

endmodule

// File: tb/tb_gpu_rect_raster.sv
// Directed bench for gpu_rect_raster.
// Instance A runs at the default 640x480 with a small FIFO model.
// Instance B runs at 20x10 so that a full-screen CLEAR stays short.
module tb_gpu_rect_raster;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    gpu_rect_raster_if bus ();
    gpu_rect_raster_if bus_b ();

    gpu_rect_raster dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    gpu_rect_raster #(.H_RES(20), .V_RES(10)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

    // FIFO model for instance A: data appears on the cycle after ren.
    logic [65:0] fifo_mem [0:15];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    assign bus.empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (bus.ren) begin
            bus.read_data <= fifo_mem[rd_cnt % 16];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Cycle counter and write/read monitor for instance A.
    int unsigned  cyc = 0;
    int unsigned  ren_cyc [$];
    int unsigned  wc [$];
    logic [18:0]  wa [$];
    logic [5:0]   wd [$];
    logic [18:0]  max_addr = '0;
    int           ren_empty = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ren) begin
            ren_cyc.push_back(cyc);
            if (bus.empty) ren_empty++;
        end
        if (bus.wen) begin
            wc.push_back(cyc);
            wa.push_back(bus.addr);
            wd.push_back(bus.dout);
            if (bus.addr > max_addr) max_addr = bus.addr;
        end
    end

    // Monitor for instance B: counts writes and flags any break in address contiguity.
    int          b_cnt = 0;
    int          b_gap = 0;
    logic [18:0] b_exp = '0;
    logic [18:0] b_last = '0;

    always @(negedge clk) begin
        if (bus_b.wen) begin
            if (bus_b.addr != b_exp) b_gap++;
            b_exp  = b_exp + 19'd1;
            b_last = bus_b.addr;
            b_cnt++;
        end
    end

    function automatic logic [65:0] cmd(input logic [1:0] op, input int x0, input int y0,
                                        input int x1, input int y1, input logic [5:0] col);
        cmd = {op, 10'(x0), 10'(y0), 10'(x1), 10'(y1), col, 18'h0};
    endfunction

    task automatic push(input logic [65:0] c);
        fifo_mem[wr_cnt % 16] = c;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.done && n < max_cyc);
        check(tag, longint'(bus.done), 1);
    endtask

    task automatic clear_log();
        ren_cyc.delete();
        wc.delete();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        int n;
        logic [18:0] exp_a [6];
        rst_n           = 1'b0;
        bus.start       = 1'b1;
        bus_b.start     = 1'b0;
        bus_b.empty     = 1'b1;
        bus_b.read_data = '0;
        push(cmd(2'b01, 10, 20, 12, 21, 6'h3F));
        #22;
        // Reset state, with a command pending and start high.
        check("rst_ren",  longint'(bus.ren), 0);
        check("rst_wen",  longint'(bus.wen), 0);
        check("rst_addr", longint'(bus.addr), 0);
        check("rst_dout", longint'(bus.dout), 0);
        check("rst_done", longint'(bus.done), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Small rectangle: latency, raster order and colour.
        wait_done(50, "r038_done");
        check("r038_nw", wa.size(), 6);
        exp_a = '{19'd12810, 19'd12811, 19'd12812, 19'd13450, 19'd13451, 19'd13452};
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                check($sformatf("r038_addr%0d", i), wa[i], exp_a[i]);
                check($sformatf("r038_dout%0d", i), wd[i], 6'h3F);
            end
        end
        if (wc.size() == 6 && ren_cyc.size() == 1) begin
            check("r038_first", wc[0], ren_cyc[0] + 2);
            check("r038_last",  wc[5], ren_cyc[0] + 7);
        end
        clear_log();

        // Clipping at the bottom-right corner.
        push(cmd(2'b01, 630, 475, 700, 600, 6'h15));
        wait_done(500, "r039_done");
        check("r039_nw", wa.size(), 50);
        if (wa.size() == 50) begin
            check("r039_first", wa[0], 304630);
            check("r039_last",  wa[49], 307199);
        end
        check("r039_max", max_addr, 307199);
        clear_log();

        // Commands that must produce no writes.
        push(cmd(2'b01, 20, 5, 10, 6, 6'h01));
        push(cmd(2'b00, 1, 1, 2, 2, 6'h02));
        push(cmd(2'b11, 1, 1, 2, 2, 6'h03));
        push(cmd(2'b01, 650, 5, 700, 6, 6'h04));
        push(cmd(2'b01, 5, 490, 6, 500, 6'h05));
        wait_done(100, "r040_done");
        check("r040_nw", wa.size(), 0);
        check("r040_nren", ren_cyc.size(), 5);
        for (int i = 0; i + 1 < ren_cyc.size(); i++)
            check($sformatf("r040_gap%0d", i), ren_cyc[i+1] - ren_cyc[i], 3);
        clear_log();

        // Back-to-back single pixels at both extremes.
        push(cmd(2'b01, 0, 0, 0, 0, 6'h0A));
        push(cmd(2'b01, 639, 479, 639, 479, 6'h0B));
        wait_done(50, "r042_done");
        check("r042_nren", ren_cyc.size(), 2);
        check("r042_nw", wa.size(), 2);
        if (ren_cyc.size() == 2 && wa.size() == 2) begin
            check("r042_gap",  ren_cyc[1] - ren_cyc[0], 4);
            check("r042_lat",  wc[0], ren_cyc[0] + 2);
            check("r042_a0",   wa[0], 0);
            check("r042_a1",   wa[1], 307199);
            check("r042_d1",   wd[1], 6'h0B);
        end
        clear_log();

        // Reset at the fifth pixel of a 4x4 fill.
        push(cmd(2'b01, 100, 200, 103, 203, 6'h2A));
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (wa.size() < 5 && n < 100);
        check("r043_reach5", wa.size(), 5);
        if (wa.size() == 5) check("r043_a4", wa[4], 128740);
        rst_n = 1'b0;
        #1;
        check("r043_rst_wen",  longint'(bus.wen), 0);
        check("r043_rst_addr", longint'(bus.addr), 0);
        check("r043_rst_done", longint'(bus.done), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("r043_nowrite", wa.size(), 5);
        check("r043_nren", ren_cyc.size(), 1);
        clear_log();

        // start dropped mid-fill: the fill completes and no further fetch occurs.
        push(cmd(2'b01, 0, 0, 1, 1, 6'h11));
        push(cmd(2'b01, 5, 5, 5, 5, 6'h22));
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (wa.size() < 1 && n < 100);
        bus.start = 1'b0;
        wait_done(50, "r029_done");
        repeat (5) @(negedge clk);
        #1;
        check("r029_nw", wa.size(), 4);
        check("r029_nren", ren_cyc.size(), 1);
        bus.start = 1'b1;
        wait_done(50, "r029_resume");
        check("r029_nren2", ren_cyc.size(), 2);
        check("r029_nw2", wa.size(), 5);
        if (wa.size() == 5) check("r029_a4", wa[4], 3205);
        check("r031_ren_empty", ren_empty, 0);
        check("r026_max", max_addr, 307199);

        // Full-screen CLEAR on the 20x10 instance; the coordinates must be ignored.
        bus_b.read_data = cmd(2'b10, 7, 3, 9, 4, 6'h00);
        bus_b.empty = 1'b0;
        bus_b.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.ren && n < 20);
        check("clr_ren_seen", longint'(bus_b.ren), 1);
        bus_b.empty = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus_b.done && n < 1000);
        check("clr_done", longint'(bus_b.done), 1);
        check("clr_count", b_cnt, 200);
        check("clr_gaps", b_gap, 0);
        check("clr_last", b_last, 199);
        check("clr_dout", longint'(bus_b.dout), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_rect_raster.md
GPU_RECT_RASTER -- requirements
Module: gpu_rect_raster

Interface
REQ-001 Parameters: H_RES, default 640, visible pixels per line. V_RES, default 480, visible lines per frame.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  run enable; new commands are fetched only while high.
REQ-005 empty  in  1  command FIFO empty flag.
REQ-006 ren  out  1  FIFO read strobe; read_data is valid on the cycle after ren.
REQ-007 read_data  in  66  command word: [65:64] op, [63:54] x0, [53:44] y0, [43:34] x1, [33:24] y1, [23:18] color, [17:0] ignored.
REQ-008 addr  out  19  framebuffer write address (H_RES*y + x).
REQ-009 dout  out  6  pixel color RRGGBB.
REQ-010 wen  out  1  framebuffer write enable; one pixel per cycle while high.
REQ-011 done  out  1  high when idle with no pending work.

Function
REQ-012 States: IDLE, FETCH, DECODE, DRAW; encoding is free.
REQ-013 IDLE -> FETCH when start=1 and empty=0; otherwise stay in IDLE.
REQ-014 FETCH: ren=1 for exactly one cycle; next state DECODE.
REQ-015 DECODE: latch read_data; ren=0; wen=0.
REQ-016 Opcodes: 00 NOP, 01 FILL_RECT, 10 CLEAR, 11 reserved (treated as NOP).
REQ-017 NOP and reserved opcodes: DECODE -> IDLE; no writes.
REQ-018 CLEAR: fill the full screen (x 0..H_RES-1, y 0..V_RES-1) with color; ignore coordinates.
REQ-019 FILL_RECT clipping: clamp x1 to H_RES-1 and y1 to V_RES-1.
REQ-020 FILL_RECT empty cases: if x0>x1, y0>y1, x0>=H_RES or y0>=V_RES after clamping, no writes; DECODE -> IDLE.
REQ-021 Non-empty FILL_RECT or CLEAR: DECODE -> DRAW.
REQ-022 DRAW writes one pixel per cycle in raster order (x ascending within a row, then y ascending); wen=1 every DRAW cycle; dout=color.
REQ-023 First write occurs 2 cycles after the ren cycle.
REQ-024 Total wen cycles = (x1-x0+1)*(y1-y0+1) after clipping.
REQ-025 addr is computed without a multiplier: the row base starts at H_RES*y0 and is incremented by H_RES per row; addr = row base + x.
REQ-026 Max addr = 307199 at default parameters; addr never exceeds H_RES*V_RES-1.
REQ-027 After the write of the last pixel (x1,y1): DRAW -> IDLE; wen=0 on the next cycle.
REQ-028 Minimum one IDLE cycle between commands; per-command overhead is 3 cycles (FETCH, DECODE, IDLE).
REQ-029 start deasserted mid-DRAW: the current command completes; no further fetch occurs until start=1.
REQ-030 empty asserted mid-command: no effect; empty is sampled only in IDLE.
REQ-031 ren is never asserted while empty=1 or in any state other than FETCH.
REQ-032 done=1 only in IDLE with (empty=1 or start=0); otherwise 0.
REQ-033 addr and dout hold their last values when wen=0; the framebuffer ignores them.

Reset
REQ-034 reset low asynchronously forces IDLE; ren=0, wen=0, addr=0, dout=0, and the latched command clears to NOP.
REQ-035 done=1 while reset is low and after release if empty=1.
REQ-036 Reset mid-DRAW aborts the command immediately; the remaining pixels are never written.
REQ-037 After reset release, first FETCH is no earlier than the first rising edge with start=1 and empty=0.

Verification
REQ-038 FILL_RECT (10,20)-(12,21), color 6'h3F -> ren at T, wen at T+2..T+7, addr 12810,12811,12812,13450,13451,13452, dout 6'h3F.
REQ-039 FILL_RECT (630,475)-(700,600) -> clipped to 639,479; 50 writes, last addr 307199, no addr > 307199.
REQ-040 FILL_RECT x0=20, x1=10 and a NOP -> zero wen cycles; each returns to IDLE 2 cycles after ren; done=1 once FIFO empty.
REQ-041 CLEAR color 6'h00 -> exactly 307200 wen cycles, addr 0..307199 contiguous.
REQ-042 Two back-to-back 1x1 rects with start=1 -> ren pulses exactly 4 cycles apart; ren=0 while empty=1.
REQ-043 reset low at the 5th pixel of a 4x4 fill -> wen=0 and addr=0 immediately; no further writes after release until a new fetch; start=0 mid-fill -> fill completes, no next ren.
